// File: rtl/dft_scan_dumper.sv
// Scan-chain dumper: freezes the DUT, recirculates NCHAIN chains and streams the bits out as packed words.
// Optional macro DFT_PARITY_EN appends a parity/dump-index word after each dump.
module dft_scan_dumper #(
    parameter int NCHAIN    = 2,
    parameter int CHAIN_LEN = 32,
    parameter int OUT_W     = 32,
    parameter int DUMP_NBR  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              val_op,
    output logic              op_ack,
    output logic              op_commit,
    input  logic              commit_ack,
    output logic              sc_sen,
    output logic              sc_ce,
    input  logic [NCHAIN-1:0] sc_sin,
    output logic [NCHAIN-1:0] sc_sout,
    output logic [OUT_W-1:0]  dft_out,
    output logic              dft_out_strobe,
    input  logic              dft_out_ready
);

    localparam int W    = OUT_W / NCHAIN;
    localparam int SH_W = $clog2(CHAIN_LEN) + 1;
    localparam int SL_W = $clog2(W) + 1;
    localparam int DN_W = $clog2(DUMP_NBR) + 1;

    typedef enum logic [2:0] {IDLE, ACK, SHIFT, EMIT, STEP, COMMIT} state_t;

    state_t            r_state, w_next;
    logic [SH_W-1:0]   r_shift;
    logic [SL_W-1:0]   r_slot;
    logic [DN_W-1:0]   r_dump;
    logic [OUT_W-1:0]  r_word;
    logic              r_bits_done;
    logic              w_last_shift, w_word_full, w_accept, w_more;

`ifdef DFT_PARITY_EN
    logic              r_par, r_par_sent, r_gap;
    logic [OUT_W-1:0]  w_par_word;
    assign w_par_word = {(OUT_W-1)'(r_dump), r_par};
`endif

    assign w_last_shift = (r_shift == SH_W'(CHAIN_LEN - 1));
    assign w_word_full  = (r_slot == SL_W'(W - 1));
    assign w_accept     = dft_out_strobe & dft_out_ready;
    assign w_more       = (r_dump < DN_W'(DUMP_NBR - 1));
    // Chains recirculate so their content is restored after a full dump.
    assign sc_sout      = sc_sin;
    assign dft_out      = r_word;

    always_comb begin
        w_next         = r_state;
        op_ack         = 1'b0;
        op_commit      = 1'b0;
        sc_sen         = 1'b0;
        sc_ce          = 1'b0;
        dft_out_strobe = 1'b0;
        case (r_state)
            IDLE: begin
                sc_ce = 1'b1;
                if (val_op) w_next = ACK;
            end
            ACK: begin
                op_ack = 1'b1;
                w_next = SHIFT;
            end
            SHIFT: begin
                sc_sen = 1'b1;
                sc_ce  = 1'b1;
                if (w_last_shift || w_word_full) w_next = EMIT;
            end
            EMIT: begin
`ifdef DFT_PARITY_EN
                dft_out_strobe = ~r_gap;
`else
                dft_out_strobe = 1'b1;
`endif
                if (w_accept) begin
                    if (!r_bits_done) w_next = SHIFT;
`ifdef DFT_PARITY_EN
                    else if (!r_par_sent) w_next = EMIT;
`endif
                    else if (w_more) w_next = STEP;
                    else w_next = COMMIT;
                end
            end
            STEP: begin
                sc_ce  = 1'b1;
                w_next = SHIFT;
            end
            COMMIT: begin
                op_commit = 1'b1;
                if (commit_ack) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_slot      <= '0;
            r_dump      <= '0;
            r_word      <= '0;
            r_bits_done <= 1'b0;
`ifdef DFT_PARITY_EN
            r_par       <= 1'b0;
            r_par_sent  <= 1'b0;
            r_gap       <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                ACK: begin
                    r_shift     <= '0;
                    r_slot      <= '0;
                    r_dump      <= '0;
                    r_word      <= '0;
                    r_bits_done <= 1'b0;
`ifdef DFT_PARITY_EN
                    r_par       <= 1'b0;
                    r_par_sent  <= 1'b0;
                    r_gap       <= 1'b0;
`endif
                end
                SHIFT: begin
                    r_word[r_slot*NCHAIN +: NCHAIN] <= sc_sin;
                    r_slot <= r_slot + 1'b1;
`ifdef DFT_PARITY_EN
                    r_par  <= r_par ^ (^sc_sin);
`endif
                    if (w_last_shift) begin
                        r_shift     <= '0;
                        r_bits_done <= 1'b1;
                    end else begin
                        r_shift <= r_shift + 1'b1;
                    end
                end
                EMIT: begin
`ifdef DFT_PARITY_EN
                    r_gap <= 1'b0;
`endif
                    if (w_accept) begin
                        r_word <= '0;
                        r_slot <= '0;
                        if (r_bits_done) begin
`ifdef DFT_PARITY_EN
                            // Parity word follows after a one-cycle strobe gap.
                            if (!r_par_sent) begin
                                r_word     <= w_par_word;
                                r_par_sent <= 1'b1;
                                r_gap      <= 1'b1;
                            end else begin
                                r_dump      <= r_dump + 1'b1;
                                r_bits_done <= 1'b0;
                                r_par_sent  <= 1'b0;
                                r_par       <= 1'b0;
                            end
`else
                            r_dump      <= r_dump + 1'b1;
                            r_bits_done <= 1'b0;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dft_scan_dumper.sv
// Directed bench: two dumper instances (32-bit chains x1 dump, 20-bit chains x2 dumps) against a scan-chain model.
module tb_dft_scan_dumper;

`ifdef DFT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]            rst, val_op, commit_ack, rdy;
    logic [1:0]            op_ack, op_commit, sen, ce, strobe;
    logic [1:0][1:0]       sin, sout;
    logic [1:0][31:0]      dout;
    logic [1:0]            ld;
    logic [1:0][1:0][31:0] ld_val;
    logic [1:0][1:0][31:0] chain;

    dft_scan_dumper #(.NCHAIN(2), .CHAIN_LEN(32), .OUT_W(32), .DUMP_NBR(1)) u_a (
        .clk(clk), .reset(rst[0]), .val_op(val_op[0]), .op_ack(op_ack[0]),
        .op_commit(op_commit[0]), .commit_ack(commit_ack[0]), .sc_sen(sen[0]), .sc_ce(ce[0]),
        .sc_sin(sin[0]), .sc_sout(sout[0]), .dft_out(dout[0]), .dft_out_strobe(strobe[0]),
        .dft_out_ready(rdy[0]));

    dft_scan_dumper #(.NCHAIN(2), .CHAIN_LEN(20), .OUT_W(32), .DUMP_NBR(2)) u_b (
        .clk(clk), .reset(rst[1]), .val_op(val_op[1]), .op_ack(op_ack[1]),
        .op_commit(op_commit[1]), .commit_ack(commit_ack[1]), .sc_sen(sen[1]), .sc_ce(ce[1]),
        .sc_sin(sin[1]), .sc_sout(sout[1]), .dft_out(dout[1]), .dft_out_strobe(strobe[1]),
        .dft_out_ready(rdy[1]));

    function automatic int len_of(int i);
        return (i == 0) ? 32 : 20;
    endfunction

    function automatic int dn_of(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Scan chain model: bit 0 is the scan-out end, scan-in enters at bit len-1.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++)
                if (ld[i]) chain[i][c] <= ld_val[i][c];
                else if (sen[i] && ce[i])
                    chain[i][c] <= (chain[i][c] >> 1) | (32'(sout[i][c]) << (len_of(i) - 1));
    end

    always_comb begin
        sin = '0;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++)
                sin[i][c] = chain[i][c][0];
    end

    logic [32:0] wq[$];
    int          acks[2]  = '{0, 0};
    int          steps[2] = '{0, 0};
    bit          busy[2]  = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (strobe[i] && rdy[i]) wq.push_back({1'(i), dout[i]});
            if (op_ack[i]) acks[i] <= acks[i] + 1;
            if (busy[i] && ce[i] && !sen[i]) steps[i] <= steps[i] + 1;
            if (rst[i]) busy[i] <= 1'b0;
            else if (op_ack[i]) busy[i] <= 1'b1;
            else if (op_commit[i]) busy[i] <= 1'b0;
        end
    end

    int tests = 0;
    int fails = 0;
    int base_acks, base_steps, base_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] b);
        ld_val[i][0] = a;
        ld_val[i][1] = b;
        ld[i] = 1'b1;
        tick();
        ld[i] = 1'b0;
    endtask

    task automatic start_op(input int i);
        base_acks  = acks[i];
        base_steps = steps[i];
        base_q     = wq.size();
        val_op[i] = 1'b1;
        tick();
        val_op[i] = 1'b0;
        chk("op_ack_rise", 32'(op_ack[i]), 32'd1);
        chk("ack_freeze", 32'(ce[i]), 32'd0);
        tick();
        chk("op_ack_pulse", 32'(op_ack[i]), 32'd0);
    endtask

    task automatic finish_op(input int i, input bit early);
        int n = 0;
        if (early) commit_ack[i] = 1'b1;
        while (!op_commit[i] && n < 3000) begin
            tick();
            n++;
        end
        chk("commit_rise", 32'(op_commit[i]), 32'd1);
        if (!early) begin
            tick();
            chk("commit_hold", 32'({op_commit[i], ce[i]}), 32'b10);
            commit_ack[i] = 1'b1;
        end
        tick();
        commit_ack[i] = 1'b0;
        chk("commit_done", 32'({op_commit[i], ce[i]}), 32'b01);
        chk("ack_count", 32'(acks[i] - base_acks), 32'd1);
        chk("step_count", 32'(steps[i] - base_steps), 32'(dn_of(i) - 1));
    endtask

    task automatic check_words(input int i, input logic [31:0] w0, input logic [31:0] w1, input logic p);
        logic [31:0] ex[$];
        logic [31:0] got[$];
        for (int d = 0; d < dn_of(i); d++) begin
            ex.push_back(w0);
            ex.push_back(w1);
            if (PAR) ex.push_back({31'(d), p});
        end
        for (int k = base_q; k < wq.size(); k++)
            if (wq[k][32] == 1'(i)) got.push_back(wq[k][31:0]);
        chk("word_count", 32'(got.size()), 32'(ex.size()));
        for (int k = 0; k < ex.size() && k < got.size(); k++)
            chk($sformatf("word%0d_inst%0d", k, i), got[k], ex[k]);
    endtask

    typedef struct {
        int          inst;
        logic [31:0] c0, c1, w0, w1;
        logic        p;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl[NV];

    initial begin
        rst = 2'b11; val_op = '0; commit_ack = '0; rdy = 2'b11; ld = '0; ld_val = '0;
        tbl[0] = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h5555_5555, 32'h5555_5555, 1'b0};
        tbl[1] = '{0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};
        tbl[2] = '{0, 32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0};
        tbl[3] = '{0, 32'h0000_FFFF, 32'hFFFF_0000, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0};
        tbl[4] = '{0, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002, 32'h4000_0000, 1'b0};
        tbl[5] = '{0, 32'h0000_0003, 32'h0000_0001, 32'h0000_0007, 32'h0000_0000, 1'b1};
        tbl[6] = '{1, 32'h000F_FFFF, 32'h000F_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF, 1'b0};
        tbl[7] = '{1, 32'h000F_FFFF, 32'h0000_0000, 32'h5555_5555, 32'h0000_0055, 1'b0};
        tbl[8] = '{1, 32'h0008_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0040, 1'b1};

        #12;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ctl", 32'({op_ack[i], op_commit[i], sen[i], ce[i], strobe[i]}), 32'b00010);
            chk("reset_dout", dout[i], 32'd0);
        end
        load(0, 32'd0, 32'd0);
        load(1, 32'd0, 32'd0);
        rst = 2'b00;
        tick();

        for (int v = 0; v < NV; v++) begin
            int i;
            i = tbl[v].inst;
            load(i, tbl[v].c0, tbl[v].c1);
            start_op(i);
            finish_op(i, v == NV - 1);
            check_words(i, tbl[v].w0, tbl[v].w1, tbl[v].p);
            chk("chain0_restored", chain[i][0], tbl[v].c0);
            chk("chain1_restored", chain[i][1], tbl[v].c1);
        end

        // Consumer stall on the first word: DUT frozen, word held, late val_op ignored.
        begin
            logic [31:0] dsnap, csnap;
            int n = 0;
            load(0, 32'hFFFF_FFFF, 32'd0);
            rdy[0] = 1'b0;
            start_op(0);
            while (!strobe[0] && n < 200) begin
                tick();
                n++;
            end
            chk("stall_strobe_seen", 32'(strobe[0]), 32'd1);
            dsnap = dout[0];
            csnap = chain[0][0];
            val_op[0] = 1'b1;
            for (int k = 0; k < 10; k++) begin
                tick();
                chk("stall_ctl", 32'({ce[0], sen[0], strobe[0]}), 32'b001);
                chk("stall_dout", dout[0], dsnap);
                chk("stall_chain", chain[0][0], csnap);
            end
            val_op[0] = 1'b0;
            rdy[0] = 1'b1;
            tick();
            chk("strobe_drop", 32'(strobe[0]), 32'd0);
            finish_op(0, 1'b0);
            check_words(0, 32'h5555_5555, 32'h5555_5555, 1'b0);
            chk("stall_chain_restored", chain[0][0], 32'hFFFF_FFFF);
        end

        // Reset in the middle of a shift sequence, then a clean full dump.
        load(0, 32'hFFFF_FFFF, 32'd0);
        start_op(0);
        repeat (5) tick();
        rst[0] = 1'b1;
        #1;
        chk("midrst_ctl", 32'({op_ack[0], op_commit[0], sen[0], ce[0], strobe[0]}), 32'b00010);
        chk("midrst_dout", dout[0], 32'd0);
        tick();
        rst[0] = 1'b0;
        tick();
        chk("midrst_no_word", 32'(wq.size() - base_q), 32'd0);
        load(0, 32'h0000_0001, 32'd0);
        start_op(0);
        finish_op(0, 1'b0);
        check_words(0, 32'h0000_0001, 32'h0000_0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dft_scan_dumper.md
DFT_SCAN_DUMPER -- requirements
Module: dft_scan_dumper

Interface
REQ-001 SHALL have parameter NCHAIN, default 2: number of parallel scan chains (1..8).
REQ-002 SHALL have parameter CHAIN_LEN, default 32: bits per chain (2..1024).
REQ-003 SHALL have parameter OUT_W, default 32: output word width; OUT_W % NCHAIN == 0.
REQ-004 SHALL have parameter DUMP_NBR, default 1: dumps per operation (1..255).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port val_op  in  1  dump request.
REQ-008 SHALL have port op_ack  out  1  request accepted, one-cycle pulse.
REQ-009 SHALL have port op_commit  out  1  operation complete, held until commit_ack.
REQ-010 SHALL have port commit_ack  in  1  completion acknowledged.
REQ-011 SHALL have port sc_sen  out  1  DUT scan enable.
REQ-012 SHALL have port sc_ce  out  1  DUT clock enable.
REQ-013 SHALL have port sc_sin  in  NCHAIN  chain scan-outs from DUT.
REQ-014 SHALL have port sc_sout  out  NCHAIN  chain scan-ins to DUT.
REQ-015 SHALL have port dft_out  out  OUT_W  packed dump word.
REQ-016 SHALL have port dft_out_strobe  out  1  dft_out valid.
REQ-017 SHALL have port dft_out_ready  in  1  consumer accepts word.

Function
REQ-018 SHALL implement FSM states IDLE, ACK, SHIFT, EMIT, STEP, COMMIT.
REQ-019 IDLE: sc_ce=1, sc_sen=0; val_op=1 -> ACK; val_op outside IDLE SHALL be ignored (no op_ack).
REQ-020 ACK: op_ack=1 for exactly that cycle, sc_ce=0 (DUT frozen) -> SHIFT.
REQ-021 SHIFT: sc_sen=1, sc_ce=1 each cycle; all chains shift one bit; sc_sout SHALL equal sc_sin (recirculate, chain content restored after CHAIN_LEN shifts).
REQ-022 Packing: bits of shift k SHALL occupy dft_out[(k mod W)*NCHAIN +: NCHAIN], W=OUT_W/NCHAIN, chain c at offset c; first bit shifted out lands in LSBs.
REQ-023 Word full or last shift of dump -> EMIT with sc_ce=0, sc_sen=0; dft_out_strobe=1 and dft_out stable until dft_out_strobe&&dft_out_ready; then SHIFT (bits remain) or end-of-dump.
REQ-024 Words per dump SHALL be ceil(NCHAIN*CHAIN_LEN/OUT_W); unused MSBs of final partial word SHALL be 0.
REQ-025 End-of-dump: if dumps done < DUMP_NBR -> STEP (sc_sen=0, sc_ce=1 one cycle, one functional DUT clock) -> SHIFT; else -> COMMIT.
REQ-026 COMMIT: op_commit=1, sc_ce=0 until commit_ack sampled 1 -> IDLE; commit_ack in same cycle op_commit rises SHALL complete it.
REQ-027 dft_out_strobe SHALL deassert the cycle after acceptance; a word SHALL never be dropped or duplicated.
REQ-028 Shift/word/dump counters SHALL be sized $clog2 of their max +1 and SHALL not wrap within an operation.

Reset
REQ-029 reset SHALL asynchronously force IDLE, clear all counters and packer.
REQ-030 Reset values: op_ack=0, op_commit=0, sc_sen=0, sc_ce=1, dft_out=0, dft_out_strobe=0.
REQ-031 Reset mid-operation SHALL abandon the dump; partial words SHALL not be emitted; chain content restoration is not guaranteed.

Configuration
REQ-032 Macro DFT_PARITY_EN defined: after the last data word of each dump, one extra word SHALL be emitted via EMIT: bit0 = XOR of all NCHAIN*CHAIN_LEN dumped bits, bits[OUT_W-1:1] = 0-based dump index.
REQ-033 Macro DFT_PARITY_EN undefined: no parity word, no parity logic.

Verification
REQ-034 NCHAIN=2, CHAIN_LEN=32, OUT_W=32, ready=1, chain0=0xFFFFFFFF, chain1=0 -> op_ack 1 cycle after val_op, two strobes dft_out=0x55555555, op_commit, chains unchanged after.
REQ-035 Same, chain0=0x00000001, chain1=0, DFT_PARITY_EN -> words 0x00000001, 0x00000000, parity 0x00000001.
REQ-036 dft_out_ready=0 for 10 cycles at first strobe -> sc_ce=0, dft_out held 10 cycles, no shifts, no loss.
REQ-037 CHAIN_LEN=20, NCHAIN=2, chains all ones -> words 0xFFFFFFFF, 0x000000FF.
REQ-038 DUMP_NBR=2 -> exactly one STEP cycle (sc_ce=1, sc_sen=0) between dumps; 4 words total; single op_commit.
REQ-039 reset asserted mid-SHIFT -> outputs at reset values immediately; next val_op performs full dump.
